// File: rtl/dmem_lsu.sv
// Load/store unit: one LW/LBU/SW/SB at a time over the data-memory valid/yumi
// handshake, stalling the core until the response returns.
module dmem_lsu #(
  parameter int AW = 12,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          req_valid_i,
  input  logic          req_wen_i,
  input  logic          req_byte_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [31:0]   req_wdata_i,
  input  logic [RW-1:0] req_rd_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          mem_valid_o,
  output logic          mem_wen_o,
  output logic          mem_byte_o,
  output logic          mem_yumi_o,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_valid_i,
  input  logic          mem_yumi_i,
  output logic          stall_o,
  output logic          done_o,
  output logic          load_we_o,
  output logic [31:0]   load_data_o,
  output logic [RW-1:0] load_rd_o,
  output logic [1:0]    state_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ_SENT  = 2'd1,
    REQ_ACKED = 2'd2
  } dmem_req_state_e;

  dmem_req_state_e state_q, state_d;
  logic [AW-1:0]   addr_r;
  logic            wen_r;
  logic            byte_r;
  logic [31:0]     wdata_r;
  logic [RW-1:0]   rd_r;
  logic            err_r, err_d;
  logic            capture;
  logic            done;

  function automatic logic [31:0] byte_lane_zext(input logic [31:0] word,
                                                  input logic [1:0]  lane);
    return {24'b0, word[8*lane +: 8]};
  endfunction

  // Byte stores broadcast to every lane; memory picks the lane from the address.
  function automatic logic [31:0] byte_replicate(input logic [31:0] data);
    return {4{data[7:0]}};
  endfunction

  always_comb begin
    state_d = state_q;
    err_d   = err_r;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid_i) err_d = 1'b1;
        if (req_valid_i) begin
          capture = 1'b1;
          state_d = REQ_SENT;
        end
      end
      REQ_SENT: begin
        if (mem_yumi_i) begin
          if (mem_valid_i) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = REQ_ACKED;
          end
        end else if (mem_valid_i) begin
          // Response before the request was accepted: flag it, do not consume.
          err_d = 1'b1;
        end
      end
      REQ_ACKED: begin
        if (mem_valid_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      err_r   <= 1'b0;
      addr_r  <= '0;
      wen_r   <= 1'b0;
      byte_r  <= 1'b0;
      wdata_r <= '0;
      rd_r    <= '0;
    end else begin
      state_q <= state_d;
      err_r   <= err_d;
      if (capture) begin
        addr_r  <= req_addr_i;
        wen_r   <= req_wen_i;
        byte_r  <= req_byte_i;
        wdata_r <= req_wdata_i;
        rd_r    <= req_rd_i;
      end
    end
  end

  // Request fields are only presented while the request is outstanding.
  assign mem_valid_o = (state_q == REQ_SENT);
  assign mem_addr_o  = mem_valid_o ? addr_r : '0;
  assign mem_wen_o   = mem_valid_o & wen_r;
  assign mem_byte_o  = mem_valid_o & byte_r;
  assign mem_wdata_o = !mem_valid_o ? 32'd0 :
                       byte_r ? byte_replicate(wdata_r) : wdata_r;

  assign mem_yumi_o  = done;
  assign done_o      = done;
  assign stall_o     = req_valid_i & ~done;
  assign load_we_o   = done & ~wen_r;
  assign load_rd_o   = done ? rd_r : '0;
  assign load_data_o = !done ? 32'd0 :
                       byte_r ? byte_lane_zext(mem_rdata_i, addr_r[1:0]) : mem_rdata_i;
  assign state_o     = state_q;
  assign err_o       = err_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios with literal expectations, then
// randomized core/memory traffic checked against a transaction-level model.
module tb_dmem_lsu;

  localparam int AW = 12;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          req_valid_i, req_wen_i, req_byte_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic [RW-1:0] req_rd_i;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_valid_o, mem_wen_o, mem_byte_o, mem_yumi_o;
  logic [31:0]   mem_rdata_i;
  logic          mem_valid_i, mem_yumi_i;
  logic          stall_o, done_o, load_we_o;
  logic [31:0]   load_data_o;
  logic [RW-1:0] load_rd_o;
  logic [1:0]    state_o;
  logic          err_o;

  int checks = 0;
  int failures = 0;

  dmem_lsu #(.AW(AW), .RW(RW)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_byte_i(req_byte_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_valid_o(mem_valid_o),
    .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o), .mem_yumi_o(mem_yumi_o),
    .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i), .mem_yumi_i(mem_yumi_i),
    .stall_o(stall_o), .done_o(done_o), .load_we_o(load_we_o),
    .load_data_o(load_data_o), .load_rd_o(load_rd_o), .state_o(state_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Transaction-level model: is a request outstanding, has memory accepted it,
  // what was captured, and has a protocol error been seen.
  logic          m_busy, m_acked, m_err;
  logic          m_wen, m_byte;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [RW-1:0] m_rd;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_busy  <= 1'b0;
      m_acked <= 1'b0;
      m_err   <= 1'b0;
    end else if (!m_busy) begin
      if (mem_valid_i) m_err <= 1'b1;
      if (req_valid_i) begin
        m_busy  <= 1'b1;
        m_acked <= 1'b0;
        m_wen   <= req_wen_i;
        m_byte  <= req_byte_i;
        m_addr  <= req_addr_i;
        m_wdata <= req_wdata_i;
        m_rd    <= req_rd_i;
      end
    end else if (!m_acked) begin
      if (mem_yumi_i && mem_valid_i) m_busy <= 1'b0;
      else if (mem_yumi_i)           m_acked <= 1'b1;
      else if (mem_valid_i)          m_err <= 1'b1;
    end else if (mem_valid_i) begin
      m_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic        e_done, e_mvalid;
    logic [31:0] e_wdata, e_ldata;
    logic [1:0]  e_state;
    e_done   = m_busy && mem_valid_i && (m_acked || mem_yumi_i);
    e_mvalid = m_busy && !m_acked;
    e_state  = !m_busy ? 2'd0 : (m_acked ? 2'd2 : 2'd1);
    e_wdata  = m_byte ? (m_wdata & 32'hFF) * 32'h01010101 : m_wdata;
    e_ldata  = m_byte ? (mem_rdata_i >> (8 * (m_addr % 4))) & 32'hFF : mem_rdata_i;
    chk("m_state", 32'(state_o), 32'(e_state));
    chk("m_mem_valid", 32'(mem_valid_o), 32'(e_mvalid));
    chk("m_done", 32'(done_o), 32'(e_done));
    chk("m_mem_yumi", 32'(mem_yumi_o), 32'(e_done));
    chk("m_stall", 32'(stall_o), 32'(req_valid_i && !e_done));
    chk("m_err", 32'(err_o), 32'(m_err));
    chk("m_load_we", 32'(load_we_o), 32'(e_done && !m_wen));
    if (e_mvalid) begin
      chk("m_mem_addr", 32'(mem_addr_o), 32'(m_addr));
      chk("m_mem_wen", 32'(mem_wen_o), 32'(m_wen));
      chk("m_mem_byte", 32'(mem_byte_o), 32'(m_byte));
      chk("m_mem_wdata", mem_wdata_o, e_wdata);
    end
    if (e_done && !m_wen) begin
      chk("m_load_data", load_data_o, e_ldata);
      chk("m_load_rd", 32'(load_rd_o), 32'(m_rd));
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare_model();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic wen, input logic byt,
                         input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic [RW-1:0] rd);
    req_valid_i = v; req_wen_i = wen; req_byte_i = byt;
    req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
  endtask

  task automatic set_mem(input logic yumi, input logic vld, input logic [31:0] rdata);
    mem_yumi_i = yumi; mem_valid_i = vld; mem_rdata_i = rdata;
  endtask

  // Single load with ack and response in the same cycle; returns load data.
  task automatic quick_load(input logic byt, input logic [AW-1:0] addr,
                            input logic [31:0] rdata, output logic [31:0] data);
    set_req(1'b1, 1'b0, byt, addr, 32'd0, 5'd7);
    set_mem(1'b0, 1'b0, 32'd0);
    sample(); adv();
    set_mem(1'b1, 1'b1, rdata);
    sample();
    chk("quick_done", 32'(done_o), 32'd1);
    data = load_data_o;
    adv();
    set_req(1'b0, 1'b0, 1'b0, '0, 32'd0, '0);
    set_mem(1'b0, 1'b0, 32'd0);
  endtask

  logic [31:0] ld;
  logic        prev_done;

  initial begin
    n_reset = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, '0, 32'd0, '0);
    set_mem(1'b0, 1'b0, 32'd0);
    sample();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    adv();
    req_valid_i = 1'b0;
    n_reset = 1'b1;
    sample(); adv();

    // SW 0x010: ack in cycle 1, response in cycle 3.
    set_req(1'b1, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 5'd0);
    sample();
    chk("sw_c0_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("sw_c0_stall", 32'(stall_o), 32'd1);
    adv();
    set_mem(1'b1, 1'b0, 32'd0);
    sample();
    chk("sw_c1_mem_valid", 32'(mem_valid_o), 32'd1);
    chk("sw_c1_addr", 32'(mem_addr_o), 32'h010);
    chk("sw_c1_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("sw_c1_wen", 32'(mem_wen_o), 32'd1);
    adv();
    set_mem(1'b0, 1'b0, 32'd0);
    sample();
    chk("sw_c2_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("sw_c2_state", 32'(state_o), 32'd2);
    chk("sw_c2_stall", 32'(stall_o), 32'd1);
    adv();
    set_mem(1'b0, 1'b1, 32'h0);
    sample();
    chk("sw_c3_done", 32'(done_o), 32'd1);
    chk("sw_c3_load_we", 32'(load_we_o), 32'd0);
    chk("sw_c3_stall", 32'(stall_o), 32'd0);
    adv();
    set_req(1'b0, 1'b0, 1'b0, '0, 32'd0, '0);
    set_mem(1'b0, 1'b0, 32'd0);
    sample(); adv();

    // LW 0x020 with same-cycle ack+response.
    set_req(1'b1, 1'b0, 1'b0, 12'h020, 32'd0, 5'd5);
    sample(); adv();
    set_mem(1'b1, 1'b1, 32'h12345678);
    sample();
    chk("lw_done", 32'(done_o), 32'd1);
    chk("lw_load_we", 32'(load_we_o), 32'd1);
    chk("lw_data", load_data_o, 32'h12345678);
    chk("lw_rd", 32'(load_rd_o), 32'd5);
    adv();
    set_req(1'b0, 1'b0, 1'b0, '0, 32'd0, '0);
    set_mem(1'b0, 1'b0, 32'd0);

    // LBU lane selection.
    quick_load(1'b1, 12'h023, 32'hAABBCCDD, ld);
    chk("lbu_023", ld, 32'h000000AA);
    quick_load(1'b1, 12'h020, 32'hAABBCCDD, ld);
    chk("lbu_020", ld, 32'h000000DD);
    quick_load(1'b1, 12'h021, 32'hAABBCCDD, ld);
    chk("lbu_021", ld, 32'h000000CC);

    // SB replicates the byte across the word.
    set_req(1'b1, 1'b1, 1'b1, 12'h042, 32'h000000F1, 5'd0);
    sample(); adv();
    set_mem(1'b1, 1'b1, 32'd0);
    sample();
    chk("sb_wdata", mem_wdata_o, 32'hF1F1F1F1);
    chk("sb_byte", 32'(mem_byte_o), 32'd1);
    chk("sb_done", 32'(done_o), 32'd1);
    adv();
    set_req(1'b0, 1'b0, 1'b0, '0, 32'd0, '0);
    set_mem(1'b0, 1'b0, 32'd0);

    // Ack withheld for 5 cycles.
    set_req(1'b1, 1'b1, 1'b0, 12'h3FC, 32'hCAFEF00D, 5'd0);
    sample(); adv();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("hold_mem_valid", 32'(mem_valid_o), 32'd1);
      chk("hold_addr", 32'(mem_addr_o), 32'h3FC);
      chk("hold_stall", 32'(stall_o), 32'd1);
      chk("hold_state", 32'(state_o), 32'd1);
      adv();
    end
    set_mem(1'b1, 1'b1, 32'd0);
    sample();
    chk("hold_done", 32'(done_o), 32'd1);
    chk("clean_err", 32'(err_o), 32'd0);
    adv();
    set_req(1'b0, 1'b0, 1'b0, '0, 32'd0, '0);
    set_mem(1'b0, 1'b0, 32'd0);

    // Reset while in REQ_ACKED, then a late response in IDLE.
    set_req(1'b1, 1'b0, 1'b0, 12'h100, 32'd0, 5'd3);
    sample(); adv();
    set_mem(1'b1, 1'b0, 32'd0);
    sample(); adv();
    set_mem(1'b0, 1'b0, 32'd0);
    sample();
    chk("r6_acked", 32'(state_o), 32'd2);
    adv();
    n_reset = 1'b0;
    set_mem(1'b0, 1'b1, 32'h55555555);
    sample();
    chk("r6_rst_state", 32'(state_o), 32'd0);
    chk("r6_rst_done", 32'(done_o), 32'd0);
    chk("r6_rst_yumi", 32'(mem_yumi_o), 32'd0);
    chk("r6_rst_load_we", 32'(load_we_o), 32'd0);
    chk("r6_rst_stall", 32'(stall_o), 32'd1);
    adv();
    n_reset = 1'b1;
    req_valid_i = 1'b0;
    sample();
    chk("r6_late_done", 32'(done_o), 32'd0);
    adv();
    set_mem(1'b0, 1'b0, 32'd0);
    sample();
    chk("r6_err", 32'(err_o), 32'd1);
    chk("r6_idle", 32'(state_o), 32'd0);
    adv();

    // Clear the sticky error, then randomized traffic.
    n_reset = 1'b0;
    sample(); adv();
    n_reset = 1'b1;
    prev_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!req_valid_i || prev_done)
        set_req(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                AW'($urandom), $urandom, RW'($urandom));
      mem_rdata_i = $urandom;
      if (m_busy) begin
        mem_yumi_i  = 1'($urandom);
        mem_valid_i = m_acked ? (($urandom % 3) == 0)
                              : (mem_yumi_i ? (($urandom % 2) == 0) : (($urandom % 100) == 0));
      end else begin
        mem_yumi_i  = 1'($urandom);
        mem_valid_i = (($urandom % 200) == 0);
      end
      sample();
      prev_done = done_o;
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
